// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: two-stage front end (fetch slot + instruction register).
// It reads a synchronous ROM, hands the instruction fields to the control unit,
// resolves the control unit's branch requests against the ALU equal flag,
// flushes two slots on a taken branch, freezes on stall and halts on a
// branch-to-self.
module instr_fetch_unit #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [3:0]      opcode,
    output logic            sp,
    output logic [3:0]      operand,
    output logic [PC_W-1:0] pc_out,
    output logic            instr_valid,
    input  logic            branch,
    input  logic [1:0]      br_sel,
    input  logic            eq_flag,
    output logic            done
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Architectural state: fetch PC, fetch slot, instruction register.
    state_t          r_state;
    logic [PC_W-1:0] r_fpc;
    logic [PC_W-1:0] r_f_pc;
    logic            r_f_vld;
    logic [8:0]      r_ir;
    logic [PC_W-1:0] r_ir_pc;
    logic            r_ir_vld;
    // The ROM keeps reading imem_addr during a stall, so its output moves on
    // to the next word. The word belonging to the fetch slot is parked here on
    // the first stalled cycle and used when the front end resumes.
    logic            r_skid_vld;
    logic [8:0]      r_skid_data;

    state_t          w_state_nxt;
    logic [PC_W-1:0] w_fpc_nxt;
    logic [PC_W-1:0] w_f_pc_nxt;
    logic            w_f_vld_nxt;
    logic [8:0]      w_ir_nxt;
    logic [PC_W-1:0] w_ir_pc_nxt;
    logic            w_ir_vld_nxt;
    logic            w_skid_vld_nxt;
    logic [8:0]      w_skid_data_nxt;

    logic            w_cond;
    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_target;
    logic            w_taken;
    logic            w_halt;
    logic [8:0]      w_fetch_data;

    // Branch condition selected by the control unit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_cond = 1'b0;
        case (br_sel)
            2'd0:    w_cond = eq_flag;
            2'd1:    w_cond = !eq_flag;
            2'd2:    w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    // Target is PC-relative with a 5-bit signed offset; wraps modulo 2^PC_W.
    assign w_offset     = {{(PC_W-5){r_ir[4]}}, r_ir[4:0]};
    assign w_target     = r_ir_pc + w_offset;
    assign w_taken      = r_ir_vld & branch & w_cond;
    assign w_halt       = w_taken & (w_target == r_ir_pc);
    assign w_fetch_data = r_skid_vld ? r_skid_data : imem_data;

    // Next-state logic: start from IDLE/DONE, advance/flush/halt in RUN.
    always_comb begin
        w_state_nxt     = r_state;
        w_fpc_nxt       = r_fpc;
        w_f_pc_nxt      = r_f_pc;
        w_f_vld_nxt     = r_f_vld;
        w_ir_nxt        = r_ir;
        w_ir_pc_nxt     = r_ir_pc;
        w_ir_vld_nxt    = r_ir_vld;
        w_skid_vld_nxt  = r_skid_vld;
        w_skid_data_nxt = r_skid_data;
        case (r_state)
            S_RUN: begin
                if (stall) begin
                    // Frozen: only capture the in-flight ROM word once.
                    if (!r_skid_vld) begin
                        w_skid_vld_nxt  = 1'b1;
                        w_skid_data_nxt = imem_data;
                    end
                end else begin
                    w_skid_vld_nxt = 1'b0;
                    if (w_halt) begin
                        w_state_nxt  = S_DONE;
                        w_fpc_nxt    = START_PC;
                        w_f_vld_nxt  = 1'b0;
                        w_ir_vld_nxt = 1'b0;
                    end else if (w_taken) begin
                        // Squash the fetch slot and the IR; refetch from target.
                        w_fpc_nxt    = w_target;
                        w_f_vld_nxt  = 1'b0;
                        w_ir_vld_nxt = 1'b0;
                    end else begin
                        w_ir_nxt     = w_fetch_data;
                        w_ir_pc_nxt  = r_f_pc;
                        w_ir_vld_nxt = r_f_vld;
                        w_f_pc_nxt   = r_fpc;
                        w_f_vld_nxt  = 1'b1;
                        w_fpc_nxt    = r_fpc + PC_W'(1);
                    end
                end
            end
            default: begin
                // IDLE and DONE behave the same: wait for start.
                if (start) begin
                    w_state_nxt    = S_RUN;
                    w_f_pc_nxt     = START_PC;
                    w_f_vld_nxt    = 1'b1;
                    w_fpc_nxt      = START_PC + PC_W'(1);
                    w_ir_vld_nxt   = 1'b0;
                    w_skid_vld_nxt = 1'b0;
                end
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fpc       <= START_PC;
            r_f_pc      <= '0;
            r_f_vld     <= 1'b0;
            r_ir        <= '0;
            r_ir_pc     <= '0;
            r_ir_vld    <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fpc       <= w_fpc_nxt;
            r_f_pc      <= w_f_pc_nxt;
            r_f_vld     <= w_f_vld_nxt;
            r_ir        <= w_ir_nxt;
            r_ir_pc     <= w_ir_pc_nxt;
            r_ir_vld    <= w_ir_vld_nxt;
            r_skid_vld  <= w_skid_vld_nxt;
            r_skid_data <= w_skid_data_nxt;
        end
    end

    assign imem_addr   = r_fpc;
    assign opcode      = r_ir[8:5];
    assign sp          = r_ir[4];
    assign operand     = r_ir[3:0];
    assign pc_out      = r_ir_pc;
    assign instr_valid = r_ir_vld & (r_state == S_RUN);
    assign done        = (r_state == S_DONE);

endmodule
